// File: rtl/array_search_pkg.sv
// Shared types and width helpers for the array_search engine.
package array_search_pkg;

    // Search modes carried on the request.
    typedef enum logic [1:0] {
        INDEX_FIRST   = 2'd0,
        INDEX_LAST    = 2'd1,
        COUNT_LESS    = 2'd2,
        COUNT_GREATER = 2'd3
    } searchMode_e;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } searchState_e;

    localparam int DEFAULT_WIDTH   = 12;
    localparam int DEFAULT_NAREA   = 10;
    localparam int DEFAULT_NARRAYS = 20;

    // Heap address width covering every array area.
    function automatic int calcAw(input int nArrays, input int nArea);
        return $clog2(nArrays * nArea);
    endfunction

    // Result width able to hold 0..nArea (index or count).
    function automatic int calcRw(input int nArea);
        return $clog2(nArea + 1);
    endfunction

endpackage

// File: rtl/array_search_if.sv
// Decoder handshake plus heap read port of the array_search engine.
interface array_search_if #(
    parameter int WIDTH   = array_search_pkg::DEFAULT_WIDTH,
    parameter int NAREA   = array_search_pkg::DEFAULT_NAREA,
    parameter int NARRAYS = array_search_pkg::DEFAULT_NARRAYS
) ();
    localparam int AW = array_search_pkg::calcAw(NARRAYS, NAREA);
    localparam int RW = array_search_pkg::calcRw(NAREA);

    logic                              start;
    array_search_pkg::searchMode_e     mode;
    logic [AW-1:0]                     array;
    logic [RW-1:0]                     size;
    logic [WIDTH-1:0]                  key;
    logic                              mem_rd;
    logic [AW-1:0]                     mem_addr;
    logic [WIDTH-1:0]                  mem_data;
    logic                              busy;
    logic                              done;
    logic [RW-1:0]                     result;
    logic                              err;

    // Requester side (decoder and heap memory).
    modport master (
        output start, mode, array, size, key, mem_data,
        input  mem_rd, mem_addr, busy, done, result, err
    );

    // Search engine side.
    modport slave (
        input  start, mode, array, size, key, mem_data,
        output mem_rd, mem_addr, busy, done, result, err
    );
endinterface

// File: rtl/array_search_cmp.sv
// One-stage compare-and-accumulate for array_search. The accumulator output
// already includes the datum presented this cycle, so the controller can
// capture a final result on the same edge that it leaves the scan.
module array_search_cmp
    import array_search_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int RW    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  searchMode_e      mode,
    input  logic [WIDTH-1:0] key,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    input  logic [RW-1:0]    index,
    output logic             hit,
    output logic [RW-1:0]    accumulator
);
    localparam logic [RW-1:0] ONE_RW = RW'(1);

    logic [RW-1:0] accR;
    logic [RW-1:0] accS;
    logic          eqS;
    logic          ltS;
    logic          gtS;

    // Unsigned compare of the returning datum and next accumulator value.
    always_comb begin
        eqS = (data == key);
        ltS = (data < key);
        gtS = (data > key);
        hit = 1'b0;
        accS = accR;
        if (valid) begin
            case (mode)
                INDEX_FIRST, INDEX_LAST: begin
                    if (eqS) begin
                        hit  = 1'b1;
                        accS = index + ONE_RW;
                    end else begin
                        accS = accR;
                    end
                end
                COUNT_LESS: begin
                    if (ltS) begin
                        accS = accR + ONE_RW;
                    end else begin
                        accS = accR;
                    end
                end
                COUNT_GREATER: begin
                    if (gtS) begin
                        accS = accR + ONE_RW;
                    end else begin
                        accS = accR;
                    end
                end
                default: accS = accR;
            endcase
        end else begin
            accS = accR;
        end
    end

    // Accumulator register, cleared when a new request is accepted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            accR <= '0;
        end else if (clear) begin
            accR <= '0;
        end else begin
            accR <= accS;
        end
    end

    assign accumulator = accS;

endmodule

// File: rtl/array_search.sv
// Sequential search/count engine over one heap array: streams the live
// elements through a single read port and returns a 1-based index or a count.
module array_search
    import array_search_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int NAREA   = DEFAULT_NAREA,
    parameter int NARRAYS = DEFAULT_NARRAYS
) (
    input  logic         clock,
    input  logic         reset,
    array_search_if.slave bus
);
    localparam int AW = calcAw(NARRAYS, NAREA);
    localparam int RW = calcRw(NAREA);

    localparam logic [AW:0]   NARRAYS_W = (AW + 1)'(NARRAYS);
    localparam logic [AW-1:0] NAREA_AW  = AW'(NAREA);
    localparam logic [RW-1:0] NAREA_RW  = RW'(NAREA);
    localparam logic [RW-1:0] ONE_RW    = RW'(1);
    localparam logic [AW-1:0] ONE_AW    = AW'(1);

    searchState_e     stateR, stateS;
    searchMode_e      modeR, modeS;
    logic [WIDTH-1:0] keyR, keyS;
    logic [RW-1:0]    lastIdxR, lastIdxS;
    logic [RW-1:0]    issueIdxR, issueIdxS;
    logic [AW-1:0]    addrR, addrS;
    logic             memRdR, memRdS;
    logic             busyR, busyS;
    logic             doneR, doneS;
    logic [RW-1:0]    resultR, resultS;
    logic             errR, errS;
    logic             errPendR, errPendS;
    logic             clearS;
    logic             dataValidR;
    logic [RW-1:0]    dataIdxR;

    logic             legalS;
    logic             overS;
    logic [RW-1:0]    countS;
    logic [AW-1:0]    baseS;
    logic             cmpValidS;
    logic             cmpHitS;
    logic [RW-1:0]    cmpAccS;
    logic             firstHitS;

    // Request decode: legality, size clamp and array base address.
    always_comb begin
        legalS = ({1'b0, bus.array} < NARRAYS_W);
        overS  = (bus.size > NAREA_RW);
        if (overS) begin
            countS = NAREA_RW;
        end else begin
            countS = bus.size;
        end
        baseS = bus.array * NAREA_AW;
    end

    // Only data belonging to the active scan reaches the comparator; the
    // datum still in flight after an early INDEX_FIRST exit is dropped.
    always_comb begin
        cmpValidS = dataValidR && ((stateR == ISSUE) || (stateR == DRAIN));
        firstHitS = cmpHitS && (modeR == INDEX_FIRST);
    end

    array_search_cmp #(
        .WIDTH (WIDTH),
        .RW    (RW)
    ) u_cmp (
        .clock       (clock),
        .reset       (reset),
        .clear       (clearS),
        .mode        (modeR),
        .key         (keyR),
        .data        (bus.mem_data),
        .valid       (cmpValidS),
        .index       (dataIdxR),
        .hit         (cmpHitS),
        .accumulator (cmpAccS)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stateR <= IDLE;
        end else begin
            stateR <= stateS;
        end
    end

    // Next-state and next-output logic; outputs are registered below.
    always_comb begin
        stateS    = stateR;
        modeS     = modeR;
        keyS      = keyR;
        lastIdxS  = lastIdxR;
        issueIdxS = issueIdxR;
        addrS     = addrR;
        memRdS    = memRdR;
        busyS     = busyR;
        doneS     = 1'b0;
        resultS   = resultR;
        errS      = errR;
        errPendS  = errPendR;
        clearS    = 1'b0;
        case (stateR)
            IDLE: begin
                if (bus.start) begin
                    busyS  = 1'b1;
                    clearS = 1'b1;
                    modeS  = bus.mode;
                    keyS   = bus.key;
                    if (!legalS) begin
                        stateS  = DONE;
                        doneS   = 1'b1;
                        resultS = '0;
                        errS    = 1'b1;
                    end else if (bus.size == '0) begin
                        stateS  = DONE;
                        doneS   = 1'b1;
                        resultS = '0;
                        errS    = 1'b0;
                    end else begin
                        stateS    = ISSUE;
                        memRdS    = 1'b1;
                        addrS     = baseS;
                        issueIdxS = '0;
                        lastIdxS  = countS - ONE_RW;
                        errPendS  = overS;
                    end
                end else begin
                    stateS = IDLE;
                end
            end
            ISSUE: begin
                if (firstHitS) begin
                    stateS  = DONE;
                    memRdS  = 1'b0;
                    doneS   = 1'b1;
                    resultS = cmpAccS;
                    errS    = errPendR;
                end else if (issueIdxR == lastIdxR) begin
                    stateS = DRAIN;
                    memRdS = 1'b0;
                end else begin
                    addrS     = addrR + ONE_AW;
                    issueIdxS = issueIdxR + ONE_RW;
                end
            end
            DRAIN: begin
                stateS  = DONE;
                doneS   = 1'b1;
                resultS = cmpAccS;
                errS    = errPendR;
            end
            DONE: begin
                stateS = IDLE;
                busyS  = 1'b0;
            end
            default: begin
                stateS = IDLE;
                busyS  = 1'b0;
                memRdS = 1'b0;
            end
        endcase
    end

    // Request context and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            modeR     <= INDEX_FIRST;
            keyR      <= '0;
            lastIdxR  <= '0;
            issueIdxR <= '0;
            addrR     <= '0;
            memRdR    <= 1'b0;
            busyR     <= 1'b0;
            doneR     <= 1'b0;
            resultR   <= '0;
            errR      <= 1'b0;
            errPendR  <= 1'b0;
        end else begin
            modeR     <= modeS;
            keyR      <= keyS;
            lastIdxR  <= lastIdxS;
            issueIdxR <= issueIdxS;
            addrR     <= addrS;
            memRdR    <= memRdS;
            busyR     <= busyS;
            doneR     <= doneS;
            resultR   <= resultS;
            errR      <= errS;
            errPendR  <= errPendS;
        end
    end

    // Tracks which element the memory returns on the next cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dataValidR <= 1'b0;
            dataIdxR   <= '0;
        end else begin
            dataValidR <= memRdR;
            dataIdxR   <= issueIdxR;
        end
    end

    assign bus.mem_rd   = memRdR;
    assign bus.mem_addr = addrR;
    assign bus.busy     = busyR;
    assign bus.done     = doneR;
    assign bus.result   = resultR;
    assign bus.err      = errR;

endmodule

// File: tb/tb_array_search.sv
// Directed bench for array_search with a one-cycle-latency heap model.
module tb_array_search;
    import array_search_pkg::*;

    localparam int WIDTH   = 12;
    localparam int NAREA   = 10;
    localparam int NARRAYS = 20;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    int   doneCyc;
    int   reads;
    int   minAddr;
    int   maxAddr;
    int   extraDone;
    int   resV;
    int   errV;

    logic [WIDTH-1:0] heap [0:NARRAYS*NAREA-1];

    array_search_if #(.WIDTH(WIDTH), .NAREA(NAREA), .NARRAYS(NARRAYS)) bus ();

    array_search #(.WIDTH(WIDTH), .NAREA(NAREA), .NARRAYS(NARRAYS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Heap memory: data valid the cycle after the read enable.
    always @(posedge clock) begin
        if (bus.mem_rd) begin
            bus.mem_data <= heap[bus.mem_addr];
        end
    end

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Issue one request and watch it; cycle 1 is the cycle after acceptance.
    task automatic runSearch(input searchMode_e m, input int arr, input int sz, input int k,
                             input int pulseCyc, input int trail);
        doneCyc = -1; reads = 0; minAddr = 9999; maxAddr = -1; extraDone = 0;
        resV = -1; errV = -1;
        @(negedge clock);
        bus.mode  = m;
        bus.array = 8'(arr);
        bus.size  = 4'(sz);
        bus.key   = 12'(k);
        bus.start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        for (int c = 1; c <= 60; c++) begin
            if (c == pulseCyc) begin
                bus.start = 1'b1;
                bus.mode  = INDEX_FIRST;
                bus.array = 8'd0;
                bus.size  = 4'd3;
                bus.key   = 12'd10;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.mem_rd) begin
                reads++;
                if (int'(bus.mem_addr) < minAddr) minAddr = int'(bus.mem_addr);
                if (int'(bus.mem_addr) > maxAddr) maxAddr = int'(bus.mem_addr);
            end
            if (bus.done) begin
                if (doneCyc < 0) begin
                    doneCyc = c;
                    resV = int'(bus.result);
                    errV = int'(bus.err);
                end else begin
                    extraDone++;
                end
            end
            if (doneCyc >= 0 && c >= doneCyc + trail) break;
            @(negedge clock);
        end
        bus.start = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        for (int a = 0; a < NARRAYS*NAREA; a++) heap[a] = 12'd0;
        heap[0]  = 12'd10; heap[1]  = 12'd20; heap[2]  = 12'd30;
        for (int a = 0; a < 10; a++) heap[10 + a] = 12'(a + 1);
        heap[20] = 12'd5;  heap[21] = 12'd7;  heap[22] = 12'd5; heap[23] = 12'd9;
        bus.start = 1'b0; bus.mode = INDEX_FIRST; bus.array = 8'd0;
        bus.size = 4'd0; bus.key = 12'd0; bus.mem_data = 12'd0;

        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_mem_rd", int'(bus.mem_rd), 0);
        check("rst_mem_addr", int'(bus.mem_addr), 0);
        check("rst_result", int'(bus.result), 0);
        check("rst_err", int'(bus.err), 0);
        reset = 1'b0;

        // INDEX_FIRST early exit at index 1
        runSearch(INDEX_FIRST, 0, 3, 20, 0, 4);
        check("first_hit_done_cyc", doneCyc, 4);
        check("first_hit_result", resV, 2);
        check("first_hit_err", errV, 0);
        check("first_hit_first_addr", minAddr, 0);
        check("first_hit_extra_done", extraDone, 0);

        // INDEX_LAST full scan
        runSearch(INDEX_LAST, 2, 4, 5, 0, 3);
        check("last_done_cyc", doneCyc, 6);
        check("last_result", resV, 3);
        check("last_reads", reads, 4);
        check("last_min_addr", minAddr, 20);
        check("last_max_addr", maxAddr, 23);
        check("last_err", errV, 0);

        runSearch(COUNT_LESS, 2, 4, 8, 0, 0);
        check("less_result", resV, 3);
        check("less_done_cyc", doneCyc, 6);
        runSearch(COUNT_GREATER, 2, 4, 8, 0, 0);
        check("greater_result", resV, 1);
        check("greater_done_cyc", doneCyc, 6);
        runSearch(INDEX_FIRST, 2, 4, 8, 0, 0);
        check("first_miss_result", resV, 0);
        check("first_miss_done_cyc", doneCyc, 6);

        // Empty array
        runSearch(INDEX_LAST, 2, 0, 5, 0, 3);
        check("size0_done_cyc", doneCyc, 1);
        check("size0_result", resV, 0);
        check("size0_reads", reads, 0);
        check("size0_err", errV, 0);

        // Illegal array number
        runSearch(INDEX_LAST, 20, 4, 5, 0, 3);
        check("illegal_done_cyc", doneCyc, 1);
        check("illegal_err", errV, 1);
        check("illegal_result", resV, 0);
        check("illegal_reads", reads, 0);

        // Oversize request clamped to NAREA, then back-to-back request
        runSearch(COUNT_GREATER, 1, 15, 0, 0, 0);
        check("clamp_reads", reads, 10);
        check("clamp_done_cyc", doneCyc, 12);
        check("clamp_err", errV, 1);
        check("clamp_result", resV, 10);
        check("clamp_max_addr", maxAddr, 19);
        runSearch(COUNT_LESS, 0, 3, 25, 0, 2);
        check("b2b_done_cyc", doneCyc, 5);
        check("b2b_result", resV, 2);
        check("b2b_err", errV, 0);

        // Reset during ISSUE at cycle 2
        @(negedge clock);
        bus.mode = INDEX_LAST; bus.array = 8'd2; bus.size = 4'd4; bus.key = 12'd5;
        bus.start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        @(negedge clock);
        check("pre_rst_mem_rd", int'(bus.mem_rd), 1);
        reset = 1'b1;
        #1;
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_done", int'(bus.done), 0);
        check("midrst_mem_rd", int'(bus.mem_rd), 0);
        check("midrst_mem_addr", int'(bus.mem_addr), 0);
        check("midrst_result", int'(bus.result), 0);
        check("midrst_err", int'(bus.err), 0);
        @(negedge clock);
        reset = 1'b0;
        runSearch(COUNT_GREATER, 0, 3, 15, 0, 2);
        check("post_rst_result", resV, 2);
        check("post_rst_done_cyc", doneCyc, 5);

        // start while busy is ignored
        runSearch(COUNT_LESS, 2, 4, 8, 2, 6);
        check("busy_start_result", resV, 3);
        check("busy_start_done_cyc", doneCyc, 6);
        check("busy_start_extra_done", extraDone, 0);
        check("busy_start_reads", reads, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
